// File: rtl/spi_slave_tx_ser_if.sv
// ----------------------------------------------------------------------------
// spi_slave_tx_ser_if
//
// Purpose: bundles the word-side handshake and the SPI-slave byte handshake of
// the MISO word serializer into one interface. The serializer connects through
// the 'slave' modport. The producer (MCU-side logic or a testbench) connects
// through the 'master' modport.
//
// Signals:
//   i_Ser_DV     producer -> serializer  one-cycle strobe, i_Ser_Bytes valid
//   i_Ser_Bytes  producer -> serializer  word to transmit, MSB byte goes first
//   o_Ser_Ready  serializer -> producer  holding register empty
//   i_RX_DV      SPI slave -> serializer one byte exchange finished on the bus
//   o_TX_DV      serializer -> SPI slave one-cycle strobe, load o_TX_Byte
//   o_TX_Byte    serializer -> SPI slave next byte for MISO
//   o_Word_Done  serializer -> producer  last byte of a word was exchanged
//   o_Irq        serializer -> MCU       data pending
//   o_Overflow   serializer -> producer  sticky, a word was offered while full
// ----------------------------------------------------------------------------
interface spi_slave_tx_ser_if #(
  parameter int WORD_BYTES = 8
);

  logic                      i_Ser_DV;
  logic [8*WORD_BYTES-1:0]   i_Ser_Bytes;
  logic                      o_Ser_Ready;
  logic                      i_RX_DV;
  logic                      o_TX_DV;
  logic [7:0]                o_TX_Byte;
  logic                      o_Word_Done;
  logic                      o_Irq;
  logic                      o_Overflow;

  modport slave (
    input  i_Ser_DV,
    input  i_Ser_Bytes,
    input  i_RX_DV,
    output o_Ser_Ready,
    output o_TX_DV,
    output o_TX_Byte,
    output o_Word_Done,
    output o_Irq,
    output o_Overflow
  );

  modport master (
    output i_Ser_DV,
    output i_Ser_Bytes,
    output i_RX_DV,
    input  o_Ser_Ready,
    input  o_TX_DV,
    input  o_TX_Byte,
    input  o_Word_Done,
    input  o_Irq,
    input  o_Overflow
  );

endinterface

// File: rtl/spi_slave_tx_ser.sv
// ----------------------------------------------------------------------------
// spi_slave_tx_ser
//
// Purpose: feeds multi-byte words to an SPI slave byte engine, one byte per
// bus exchange, most significant byte first. One word waits in a holding
// register while the previous word is shifted out, so consecutive words go out
// back-to-back. When nothing is pending, every byte exchange is answered with
// the IDLE_BYTE filler.
//
// Parameters:
//   WORD_BYTES  bytes per word (default 8)
//   IDLE_BYTE   filler byte sent when no word is pending (default 8'h00)
//
// Ports:
//   clk         100 MHz system clock, rising edge
//   rst_        synchronous active-low reset
//   bus         spi_slave_tx_ser_if.slave, see the interface file for signals
// ----------------------------------------------------------------------------
module spi_slave_tx_ser #(
  parameter int         WORD_BYTES = 8,
  parameter logic [7:0] IDLE_BYTE  = 8'h00
) (
  input  logic              clk,
  input  logic              rst_,
  spi_slave_tx_ser_if.slave bus
);

  localparam int WORD_W = 8 * WORD_BYTES;
  // A one-byte word would give a zero-width counter, so keep at least one bit.
  localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT
  } state_t;

  state_t              state_q;
  logic [WORD_W-1:0]   hold_q;
  logic                holdValid_q;
  logic [WORD_W-1:0]   shift_q;
  logic [WORD_W-1:0]   shift_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                rxDvWait_q;
  logic                txDv_q;
  logic [7:0]          txByte_q;
  logic                wordDone_q;
  logic                irq_q;
  logic                overflow_q;

  logic                serReady;
  logic                acceptWord;

  assign serReady   = ~holdValid_q;
  assign acceptWord = bus.i_Ser_DV & serReady;

  // Word after the current byte has been consumed; its top byte is the next
  // byte presented to the SPI slave.
  assign shift_d = shift_q << 8;

  // The exchange strobe is registered on the WAIT path only, and only while in
  // WAIT, so a strobe that shows up during LOAD is dropped rather than being
  // acted on late. This register is also what gives the two-cycle turnaround
  // from a byte exchange to the load of the following byte. The IDLE filler
  // path reacts to the raw strobe so the filler is loaded on the next cycle.
  //
  // o_Irq is a registered copy of "word pending or busy" from the previous
  // cycle. That keeps it high through the cycle in which o_Word_Done pulses
  // and lets it fall on the cycle after.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      holdValid_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      rxDvWait_q  <= 1'b0;
      txDv_q      <= 1'b0;
      txByte_q    <= IDLE_BYTE;
      wordDone_q  <= 1'b0;
      irq_q       <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rxDvWait_q <= bus.i_RX_DV & (state_q == WAIT);
      txDv_q     <= 1'b0;
      wordDone_q <= 1'b0;
      irq_q      <= holdValid_q | (state_q != IDLE);

      // Capture and the IDLE reload below can never coincide: capture needs
      // the holding register empty, reload needs it full.
      if (acceptWord) begin
        hold_q      <= bus.i_Ser_Bytes;
        holdValid_q <= 1'b1;
      end else if (bus.i_Ser_DV) begin
        overflow_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (holdValid_q) begin
            shift_q     <= hold_q;
            holdValid_q <= 1'b0;
            cnt_q       <= '0;
            txDv_q      <= 1'b1;
            txByte_q    <= hold_q[WORD_W-1 -: 8];
            state_q     <= LOAD;
          end else if (bus.i_RX_DV) begin
            txDv_q   <= 1'b1;
            txByte_q <= IDLE_BYTE;
          end
        end

        LOAD: begin
          state_q <= WAIT;
        end

        WAIT: begin
          if (rxDvWait_q) begin
            if (cnt_q == LAST_CNT) begin
              // A word waiting in the holding register is reloaded from IDLE
              // on the next cycle, with no filler between the two words.
              wordDone_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              shift_q  <= shift_d;
              cnt_q    <= cnt_q + CNT_W'(1);
              txDv_q   <= 1'b1;
              txByte_q <= shift_d[WORD_W-1 -: 8];
              state_q  <= LOAD;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_Ser_Ready = serReady;
  assign bus.o_TX_DV     = txDv_q;
  assign bus.o_TX_Byte   = txByte_q;
  assign bus.o_Word_Done = wordDone_q;
  assign bus.o_Irq       = irq_q;
  assign bus.o_Overflow  = overflow_q;

endmodule

// File: tb/tb_spi_slave_tx_ser.sv
// ----------------------------------------------------------------------------
// tb_spi_slave_tx_ser
//
// Purpose: self-checking bench for spi_slave_tx_ser. Every byte the bench
// expects on o_TX_Byte is queued when the word or filler strobe is driven. A
// monitor pops the queue on each o_TX_DV pulse and compares. Table entries
// cover single words. Hand-written sequences cover back-to-back words,
// overflow, idle filler, mid-word reset and latencies.
// ----------------------------------------------------------------------------
module tb_spi_slave_tx_ser;

  localparam int WB = 8;

  logic clk = 1'b0;
  logic rst_;

  always #5 clk = ~clk;

  spi_slave_tx_ser_if #(.WORD_BYTES(WB)) bus ();

  spi_slave_tx_ser #(
    .WORD_BYTES (WB),
    .IDLE_BYTE  (8'h00)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [63:0] word;
    int          gap;
    int          expDone;
    logic        expIrqEnd;
  } vec_t;

  vec_t        vecs[3];
  logic [7:0]  expQ[$];
  logic [7:0]  lastExp = 8'h00;
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          txCount = 0;
  int          wordDoneCount = 0;
  int          offerCycle = 0;
  int          rxCycle = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0h, expected %0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // Scoreboard consumer: each o_TX_DV pulse must match the oldest expected
  // byte, and a pulse with nothing expected is an error.
  always @(negedge clk) begin
    if (rst_ === 1'b1) begin
      if (bus.o_TX_DV === 1'b1) begin
        txCount++;
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL tx_unexpected: actual byte %02h, expected no pulse (cycle %0d)",
                   bus.o_TX_Byte, cyc);
        end else begin
          lastExp = expQ.pop_front();
          checkOutput("tx_byte", {56'd0, bus.o_TX_Byte}, {56'd0, lastExp});
        end
      end
      if (bus.o_Word_Done === 1'b1) wordDoneCount++;
    end
  end

  // Offer one word on the producer side. The word's bytes are queued as
  // expected output only when the DUT should accept it.
  task automatic applyStimulus(input logic [63:0] word, input bit push);
    @(posedge clk);
    #1;
    bus.i_Ser_DV    = 1'b1;
    bus.i_Ser_Bytes = word;
    offerCycle      = cyc;
    if (push) begin
      for (int k = 0; k < WB; k++) expQ.push_back(word[63-8*k -: 8]);
    end
    @(posedge clk);
    #1;
    bus.i_Ser_DV = 1'b0;
  endtask

  task automatic strobeRx();
    @(posedge clk);
    #1;
    bus.i_RX_DV = 1'b1;
    rxCycle     = cyc;
    @(posedge clk);
    #1;
    bus.i_RX_DV = 1'b0;
  endtask

  task automatic waitTx(input string name, input int refCycle, input int expLat);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.o_TX_DV === 1'b1) found = 1'b1;
    end
    if (!found) timeoutFail(name);
    else if (expLat >= 0) checkOutput(name, cyc - refCycle, expLat);
  endtask

  task automatic waitWordDone(input string name, input int refCycle);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.o_Word_Done === 1'b1) found = 1'b1;
    end
    if (!found) timeoutFail(name);
    else checkOutput(name, cyc - refCycle, 2);
  endtask

  // Byte 0 of a single word is already presented; run all its exchanges.
  task automatic strobeBytes(input int gap);
    for (int b = 0; b < WB; b++) begin
      repeat (gap) @(posedge clk);
      if (b == 2) begin
        @(negedge clk);
        checkOutput("tx_byte_stable", bus.o_TX_Byte, lastExp);
      end
      strobeRx();
      if (b < WB - 1) begin
        waitTx("lat_wait_to_load", rxCycle, 2);
      end else begin
        waitWordDone("lat_word_done", rxCycle);
        checkOutput("irq_at_done", bus.o_Irq, 1);
        @(negedge clk);
        checkOutput("irq_after_done", bus.o_Irq, 0);
        checkOutput("word_done_pulse", bus.o_Word_Done, 0);
      end
    end
  endtask

  task automatic sendWord(input logic [63:0] word, input int gap);
    applyStimulus(word, 1'b1);
    waitTx("lat_accept", offerCycle, 2);
    checkOutput("irq_busy", bus.o_Irq, 1);
    strobeBytes(gap);
  endtask

  // Second word offered while byte 3 of the first is on the bus; optionally a
  // third word is offered while the holding register is full.
  task automatic twoWords(input logic [63:0] w1, input logic [63:0] w2,
                          input bit inject, input logic ovfExp);
    int doneStart;
    doneStart = wordDoneCount;
    applyStimulus(w1, 1'b1);
    waitTx("lat_accept", offerCycle, 2);
    for (int b = 0; b < 2 * WB; b++) begin
      if (b == 3) begin
        applyStimulus(w2, 1'b1);
        @(negedge clk);
        checkOutput("ready_when_full", bus.o_Ser_Ready, 0);
        if (inject) begin
          applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
          @(negedge clk);
          checkOutput("overflow_set", bus.o_Overflow, 1);
        end
      end
      repeat (10) @(posedge clk);
      strobeRx();
      if (b == WB - 1) begin
        waitWordDone("lat_done_first", rxCycle);
        waitTx("lat_b2b_reload", rxCycle, 3);
        checkOutput("irq_between_words", bus.o_Irq, 1);
      end else if (b == 2 * WB - 1) begin
        waitWordDone("lat_done_second", rxCycle);
        @(negedge clk);
        checkOutput("irq_after_second", bus.o_Irq, 0);
      end else begin
        waitTx("lat_wait_to_load", rxCycle, 2);
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("two_word_done_count", wordDoneCount - doneStart, 2);
    checkOutput("overflow_end", bus.o_Overflow, ovfExp);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneStart;
    int txStart;
    logic [63:0] rstWord;

    vecs[0] = '{64'h0102030405060708, 20, 1, 1'b0};
    vecs[1] = '{64'h8877665544332211, 9,  1, 1'b0};
    vecs[2] = '{64'hDEADBEEFCAFE5A3C, 40, 1, 1'b0};

    rst_            = 1'b0;
    bus.i_Ser_DV    = 1'b0;
    bus.i_Ser_Bytes = '0;
    bus.i_RX_DV     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_ = 1'b1;
    @(negedge clk);
    checkOutput("rst_tx_dv",     bus.o_TX_DV,     0);
    checkOutput("rst_tx_byte",   bus.o_TX_Byte,   8'h00);
    checkOutput("rst_word_done", bus.o_Word_Done, 0);
    checkOutput("rst_irq",       bus.o_Irq,       0);
    checkOutput("rst_overflow",  bus.o_Overflow,  0);
    checkOutput("rst_ready",     bus.o_Ser_Ready, 1);

    $display("[TB] idle filler");
    txStart = txCount;
    for (int i = 0; i < 3; i++) begin
      expQ.push_back(8'h00);
      strobeRx();
      waitTx("lat_filler", rxCycle, 1);
      checkOutput("filler_irq", bus.o_Irq, 0);
      repeat (5) @(posedge clk);
    end
    @(negedge clk);
    checkOutput("filler_count", txCount - txStart, 3);

    $display("[TB] single words from table");
    for (int v = 0; v < 3; v++) begin
      doneStart = wordDoneCount;
      sendWord(vecs[v].word, vecs[v].gap);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("vec_done_count", wordDoneCount - doneStart, vecs[v].expDone);
      checkOutput("vec_irq_end", bus.o_Irq, vecs[v].expIrqEnd);
    end

    $display("[TB] back-to-back words");
    twoWords(64'h0102030405060708, 64'hA1A2A3A4A5A6A7A8, 1'b0, 1'b0);

    $display("[TB] overflow");
    twoWords(64'h1020304050607080, 64'h0F1E2D3C4B5A6978, 1'b1, 1'b1);

    $display("[TB] mid-word reset");
    doneStart = wordDoneCount;
    applyStimulus(64'h1122334455667788, 1'b1);
    waitTx("lat_accept", offerCycle, 2);
    for (int b = 0; b < 4; b++) begin
      repeat (8) @(posedge clk);
      strobeRx();
      waitTx("lat_wait_to_load", rxCycle, 2);
    end
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    expQ.delete();
    @(posedge clk);
    #1;
    rst_    = 1'b1;
    rstWord = 64'hC1C2C3C4C5C6C7C8;
    bus.i_Ser_DV    = 1'b1;
    bus.i_Ser_Bytes = rstWord;
    offerCycle      = cyc;
    for (int k = 0; k < WB; k++) expQ.push_back(rstWord[63-8*k -: 8]);
    @(negedge clk);
    checkOutput("mrst_tx_dv",     bus.o_TX_DV,     0);
    checkOutput("mrst_tx_byte",   bus.o_TX_Byte,   8'h00);
    checkOutput("mrst_word_done", bus.o_Word_Done, 0);
    checkOutput("mrst_irq",       bus.o_Irq,       0);
    checkOutput("mrst_overflow",  bus.o_Overflow,  0);
    checkOutput("mrst_ready",     bus.o_Ser_Ready, 1);
    checkOutput("mrst_no_done",   wordDoneCount - doneStart, 0);
    @(posedge clk);
    #1;
    bus.i_Ser_DV = 1'b0;
    waitTx("lat_accept_after_reset", offerCycle, 2);
    strobeBytes(6);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("mrst_done_count", wordDoneCount - doneStart, 1);

    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_slave_tx_ser.md
SPI_SLAVE_TX_SER -- requirements
Module: spi_slave_tx_ser

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 8, giving the number of bytes per transmitted word.
REQ-002 SHALL have parameter IDLE_BYTE, default 8'h00, giving the filler byte sent when no word is pending.
REQ-003 SHALL have port clk, input, 1 bit: the single 100 MHz system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port i_Ser_DV, input, 1 bit: one-cycle strobe, i_Ser_Bytes valid.
REQ-006 SHALL have port i_Ser_Bytes, input, 8*WORD_BYTES bits: word to transmit.
REQ-007 SHALL have port o_Ser_Ready, output, 1 bit: holding register empty, a word can be accepted.
REQ-008 SHALL have port i_RX_DV, input, 1 bit: SPI slave strobe, one byte exchange completed on the bus.
REQ-009 SHALL have port o_TX_DV, output, 1 bit: one-cycle strobe loading o_TX_Byte into the SPI slave.
REQ-010 SHALL have port o_TX_Byte, output, 8 bits: next byte for MISO.
REQ-011 SHALL have port o_Word_Done, output, 1 bit: one-cycle pulse when the last byte of a word has been exchanged.
REQ-012 SHALL have port o_Irq, output, 1 bit: data pending, drives the MCU interrupt line.
REQ-013 SHALL have port o_Overflow, output, 1 bit: sticky flag, a word was offered while not ready.

Function
REQ-014 SHALL hold one word in a holding register (hold, hold_valid) and one in a shift register (shift, byte counter cnt).
REQ-015 SHALL drive o_Ser_Ready = ~hold_valid combinationally.
REQ-016 SHALL capture i_Ser_Bytes into hold and set hold_valid on i_Ser_DV && o_Ser_Ready.
REQ-017 SHALL ignore i_Ser_DV when hold_valid=1, leave hold unchanged and set o_Overflow until reset.
REQ-018 SHALL implement states IDLE, LOAD and WAIT.
REQ-019 IDLE, hold_valid=1: SHALL copy hold to shift, clear hold_valid, set cnt=0 and go to LOAD.
REQ-020 IDLE, hold_valid=0, i_RX_DV=1: SHALL pulse o_TX_DV with o_TX_Byte=IDLE_BYTE the next cycle, so filler is clocked out.
REQ-021 LOAD: SHALL assert o_TX_DV for exactly one cycle with o_TX_Byte=shift[MSB -: 8] (most significant byte first) and go to WAIT.
REQ-022 WAIT, i_RX_DV=1, cnt<WORD_BYTES-1: SHALL shift left by 8, increment cnt and go to LOAD.
REQ-023 WAIT, i_RX_DV=1, cnt=WORD_BYTES-1: SHALL pulse o_Word_Done; if hold_valid go to IDLE, which reloads on the next cycle, else go to IDLE.
REQ-024 SHALL ignore i_RX_DV while in LOAD; the SPI byte time of at least 8 SCK periods makes this a protocol error.
REQ-025 SHALL keep o_TX_Byte stable between o_TX_DV pulses.
REQ-026 Latency: i_Ser_DV accepted in cycle N, with the FSM in IDLE, SHALL give o_TX_DV for byte 0 in cycle N+2.
REQ-027 From i_RX_DV in WAIT, o_TX_DV for the next byte SHALL follow 2 cycles later.
REQ-028 SHALL drive o_Irq=1 whenever hold_valid=1 or the state is not IDLE; o_Irq SHALL fall in the cycle after the o_Word_Done of the final pending word.
REQ-029 A new word accepted during WAIT of the previous word SHALL be sent back-to-back, with no IDLE_BYTE between the words.
REQ-030 cnt SHALL be $clog2(WORD_BYTES) bits wide and SHALL never wrap past WORD_BYTES-1.

Reset
REQ-031 rst_=0 at a clock edge SHALL set: state=IDLE, hold_valid=0, cnt=0, shift=0, o_TX_DV=0, o_TX_Byte=IDLE_BYTE, o_Word_Done=0, o_Irq=0, o_Overflow=0.
REQ-032 After rst_=0, o_Ser_Ready SHALL be 1.
REQ-033 Reset during a word SHALL discard both shift and hold contents, with no o_Word_Done pulse.
REQ-034 SHALL accept a word in the first cycle after rst_ returns to 1.

Verification
REQ-035 Single word: i_Ser_Bytes=64'h0102030405060708, 8 i_RX_DV strobes 20 cycles apart -> o_TX_Byte sequence 01..08, one o_Word_Done after the 8th strobe, o_Irq 1 then 0.
REQ-036 Back-to-back: second word 64'hA1A2A3A4A5A6A7A8 offered during byte 3 of the first word -> accepted, bytes 01..08 then A1..A8 with no 00 between, 2 o_Word_Done pulses.
REQ-037 Overflow: hold full and i_Ser_DV with 64'hFFFF... -> word dropped, o_Overflow=1 and stays 1, transmitted data unchanged.
REQ-038 Idle filler: no word loaded, 3 i_RX_DV strobes -> 3 o_TX_DV pulses, each with o_TX_Byte=8'h00, o_Irq=0.
REQ-039 Mid-word reset: rst_=0 for 1 cycle after byte 4 -> all outputs return to their REQ-031 values, no o_Word_Done; next word starts again from byte 0.
REQ-040 Latency check: accept at cycle N in IDLE -> o_TX_DV at N+2; i_RX_DV at M in WAIT -> o_TX_DV at M+2.
